// File: rtl/exe_stage_unit_if.sv
// ---------------------------------------------------------------------------
// exe_stage_unit_if
//   Bundles the ID-to-EXE pipeline register outputs consumed by the execute
//   stage together with the execute-stage results handed to MEM/WB and back
//   to fetch/decode.
//
//   Signals from the ID-to-EXE register (driven by master, read by slave):
//     WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN : control bits
//     EXE_CMD_IN[3:0]        : ALU command
//     PC_IN[31:0]            : PC+4 of the instruction
//     Val_Rn_IN, Val_Rm_IN   : register operands
//     imm_IN                 : operand 2 is a rotated immediate
//     Shift_operand_IN[11:0] : shifter operand field
//     Signed_imm_24_IN[23:0] : branch offset
//     Dest_IN[3:0]           : destination register
//
//   Signals produced by the execute stage (driven by slave):
//     ALU_Res, Br_Addr, branch_taken, flush, WB_EN, MEM_R_EN, MEM_W_EN,
//     Dest, Val_Rm_out, status
//
//   Modports:
//     master : the upstream side (pipeline register / testbench)
//     slave  : the execute stage itself
// ---------------------------------------------------------------------------
interface exe_stage_unit_if;
  logic        WB_EN_IN;
  logic        MEM_R_EN_IN;
  logic        MEM_W_EN_IN;
  logic        B_IN;
  logic        S_IN;
  logic [3:0]  EXE_CMD_IN;
  logic [31:0] PC_IN;
  logic [31:0] Val_Rn_IN;
  logic [31:0] Val_Rm_IN;
  logic        imm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic [3:0]  Dest_IN;

  logic [31:0] ALU_Res;
  logic [31:0] Br_Addr;
  logic        branch_taken;
  logic        flush;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [3:0]  Dest;
  logic [31:0] Val_Rm_out;
  logic [3:0]  status;

  modport master (
    output WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
           PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
           Signed_imm_24_IN, Dest_IN,
    input  ALU_Res, Br_Addr, branch_taken, flush, WB_EN, MEM_R_EN,
           MEM_W_EN, Dest, Val_Rm_out, status
  );

  modport slave (
    input  WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
           PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
           Signed_imm_24_IN, Dest_IN,
    output ALU_Res, Br_Addr, branch_taken, flush, WB_EN, MEM_R_EN,
           MEM_W_EN, Dest, Val_Rm_out, status
  );
endinterface

// File: rtl/exe_stage_unit.sv
// ---------------------------------------------------------------------------
// exe_stage_unit
//   Execute stage: builds the second ALU operand (Val2), runs the ALU, owns
//   the NZCV status register, computes the branch target and, after a taken
//   branch, squashes the next KILL_CYCLES wrong-path instructions.
//
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous reset, active low
//     bus        : exe_stage_unit_if.slave (ID-to-EXE inputs, EXE outputs)
//     br_cnt     : (EXE_PERF_CNT_EN only) taken-branch counter
//     squash_cnt : (EXE_PERF_CNT_EN only) squashed-cycle counter
//
//   Parameters:
//     KILL_CYCLES : cycles squashed after a taken branch (1..7)
//
//   Optional feature macro: EXE_PERF_CNT_EN adds the two performance
//   counters and their output ports.
// ---------------------------------------------------------------------------
module exe_stage_unit #(
  parameter int KILL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EXE_PERF_CNT_EN
  output logic [31:0]      br_cnt,
  output logic [31:0]      squash_cnt,
`endif
  exe_stage_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } state_t;

  localparam logic [2:0] KILL_INIT = 3'(KILL_CYCLES);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  state_t      state_q, state_d;
  logic [2:0]  kill_cnt_q, kill_cnt_d;
  logic [3:0]  status_q, status_d;

  logic [31:0] val2;
  logic [31:0] imm_ext;
  logic [4:0]  imm_rot;
  logic [4:0]  sh_amt;
  logic [31:0] alu_res;
  logic [32:0] sum;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cmd_valid;
  logic        squash;
  logic        run_branch;

  // Val2: rotated 8-bit immediate, 12-bit memory offset, or shifted Rm.
  // Rotations use (x >> r) | (x << (32 - r)); with r = 0 the left shift is
  // by 32 and yields 0, so the operand passes through unchanged.
  always_comb begin
    val2    = '0;
    imm_ext = {24'd0, bus.Shift_operand_IN[7:0]};
    imm_rot = {bus.Shift_operand_IN[11:8], 1'b0};
    sh_amt  = bus.Shift_operand_IN[11:7];
    if (bus.imm_IN) begin
      val2 = (imm_ext >> imm_rot) | (imm_ext << (6'd32 - {1'b0, imm_rot}));
    end else if (bus.MEM_R_EN_IN || bus.MEM_W_EN_IN) begin
      val2 = {20'd0, bus.Shift_operand_IN};
    end else begin
      case (bus.Shift_operand_IN[6:5])
        2'b00:   val2 = bus.Val_Rm_IN << sh_amt;
        2'b01:   val2 = bus.Val_Rm_IN >> sh_amt;
        2'b10:   val2 = $signed(bus.Val_Rm_IN) >>> sh_amt;
        default: val2 = (bus.Val_Rm_IN >> sh_amt) |
                        (bus.Val_Rm_IN << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end

  // ALU. Subtraction is Rn + ~Val2 + carry_in so that the carry-out is
  // directly the ARM-style "not borrow". C and V hold their old values for
  // MOV/MVN/logical ops; unknown commands leave all four flags alone.
  always_comb begin
    alu_res   = '0;
    sum       = '0;
    flag_n    = status_q[3];
    flag_z    = status_q[2];
    flag_c    = status_q[1];
    flag_v    = status_q[0];
    cmd_valid = 1'b1;
    case (bus.EXE_CMD_IN)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum     = {1'b0, bus.Val_Rn_IN} + {1'b0, val2} +
                  {32'd0, (bus.EXE_CMD_IN == CMD_ADC) ? status_q[1] : 1'b0};
        alu_res = sum[31:0];
        flag_c  = sum[32];
        flag_v  = (bus.Val_Rn_IN[31] == val2[31]) &&
                  (sum[31] != bus.Val_Rn_IN[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum     = {1'b0, bus.Val_Rn_IN} + {1'b0, ~val2} +
                  {32'd0, (bus.EXE_CMD_IN == CMD_SBC) ? status_q[1] : 1'b1};
        alu_res = sum[31:0];
        flag_c  = sum[32];
        flag_v  = (bus.Val_Rn_IN[31] != val2[31]) &&
                  (sum[31] != bus.Val_Rn_IN[31]);
      end
      CMD_AND: alu_res = bus.Val_Rn_IN & val2;
      CMD_ORR: alu_res = bus.Val_Rn_IN | val2;
      CMD_EOR: alu_res = bus.Val_Rn_IN ^ val2;
      default: begin
        alu_res   = '0;
        cmd_valid = 1'b0;
      end
    endcase
    if (cmd_valid) begin
      flag_n = alu_res[31];
      flag_z = (alu_res == 32'd0);
    end
  end

  assign squash     = (state_q == ST_KILL);
  assign run_branch = rst && !squash && bus.B_IN;

  // Next-state logic for the kill machine and the status register. The
  // counter is loaded on the branch edge and the edge seen with count 1
  // returns to RUN, giving exactly KILL_CYCLES squashed cycles.
  always_comb begin
    state_d    = state_q;
    kill_cnt_d = kill_cnt_q;
    status_d   = status_q;
    case (state_q)
      ST_RUN: begin
        if (bus.S_IN) begin
          status_d = {flag_n, flag_z, flag_c, flag_v};
        end
        if (bus.B_IN) begin
          state_d    = ST_KILL;
          kill_cnt_d = KILL_INIT;
        end
      end
      default: begin
        if (kill_cnt_q <= 3'd1) begin
          state_d    = ST_RUN;
          kill_cnt_d = 3'd0;
        end else begin
          kill_cnt_d = kill_cnt_q - 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      kill_cnt_q <= 3'd0;
      status_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      kill_cnt_q <= kill_cnt_d;
      status_q   <= status_d;
    end
  end

`ifdef EXE_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    br_cnt_d     = br_cnt_q + {31'd0, (!squash && bus.B_IN)};
    squash_cnt_d = squash_cnt_q + {31'd0, squash};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q     <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      br_cnt_q     <= br_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign br_cnt     = br_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

  assign bus.ALU_Res      = alu_res;
  assign bus.Br_Addr      = bus.PC_IN +
                            {{6{bus.Signed_imm_24_IN[23]}}, bus.Signed_imm_24_IN, 2'b00};
  assign bus.branch_taken = run_branch;
  assign bus.flush        = run_branch;
  assign bus.WB_EN        = bus.WB_EN_IN    && !squash;
  assign bus.MEM_R_EN     = bus.MEM_R_EN_IN && !squash;
  assign bus.MEM_W_EN     = bus.MEM_W_EN_IN && !squash;
  assign bus.Dest         = bus.Dest_IN;
  assign bus.Val_Rm_out   = bus.Val_Rm_IN;
  assign bus.status       = status_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// ---------------------------------------------------------------------------
// tb_exe_stage_unit
//   Directed testbench for exe_stage_unit (KILL_CYCLES = 2). A table of ALU
//   vectors is applied one per cycle, followed by hand-written branch/kill
//   and reset-during-kill sequences.
// ---------------------------------------------------------------------------
module tb_exe_stage_unit;

  logic clk;
  logic rst;
`ifdef EXE_PERF_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] squash_cnt;
`endif

  exe_stage_unit_if bus ();

  exe_stage_unit #(.KILL_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef EXE_PERF_CNT_EN
    .br_cnt     (br_cnt),
    .squash_cnt (squash_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shop;
    logic        mem_r;
    logic        s;
    logic [31:0] exp_res;
    logic [3:0]  exp_status;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic [3:0] cmd, logic [31:0] rn, logic [31:0] rm,
                              logic imm, logic [11:0] shop, logic mem_r, logic s,
                              logic [31:0] exp_res, logic [3:0] exp_status);
    vec_t v;
    v.cmd = cmd; v.rn = rn; v.rm = rm; v.imm = imm; v.shop = shop;
    v.mem_r = mem_r; v.s = s; v.exp_res = exp_res; v.exp_status = exp_status;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.WB_EN_IN         = 1'b1;
    bus.MEM_R_EN_IN      = v.mem_r;
    bus.MEM_W_EN_IN      = 1'b0;
    bus.B_IN             = 1'b0;
    bus.S_IN             = v.s;
    bus.EXE_CMD_IN       = v.cmd;
    bus.PC_IN            = 32'h0000_0040;
    bus.Val_Rn_IN        = v.rn;
    bus.Val_Rm_IN        = v.rm;
    bus.imm_IN           = v.imm;
    bus.Shift_operand_IN = v.shop;
    bus.Signed_imm_24_IN = 24'd0;
    bus.Dest_IN          = 4'd3;
  endtask

  initial begin
    // Expected status values below are cumulative: each row's S bit either
    // loads new NZCV or leaves the previous row's value.
    vec[0]  = mk(4'b0010, 32'h7FFF_FFFF, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h8000_0000, 4'b1001);
    vec[1]  = mk(4'b0100, 32'h0000_0005, 32'h5,         1'b0, 12'h000, 1'b0, 1'b1, 32'h0000_0000, 4'b0110);
    vec[2]  = mk(4'b1001, 32'h0,         32'h0,         1'b1, 12'h000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1010);
    vec[3]  = mk(4'b0011, 32'h0000_0001, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h0000_0003, 4'b0000);
    vec[4]  = mk(4'b0101, 32'h0000_000A, 32'h0,         1'b1, 12'h003, 1'b0, 1'b1, 32'h0000_0006, 4'b0010);
    vec[5]  = mk(4'b0001, 32'h0,         32'h8000_0000, 1'b0, 12'h240, 1'b0, 1'b0, 32'hF800_0000, 4'b0010);
    vec[6]  = mk(4'b0001, 32'h0,         32'h8000_0000, 1'b0, 12'h260, 1'b0, 1'b0, 32'h0800_0000, 4'b0010);
    vec[7]  = mk(4'b0001, 32'h0,         32'h8000_0000, 1'b0, 12'h220, 1'b0, 1'b0, 32'h0800_0000, 4'b0010);
    vec[8]  = mk(4'b0001, 32'h0,         32'h8000_0001, 1'b0, 12'h200, 1'b0, 1'b1, 32'h0000_0010, 4'b0010);
    vec[9]  = mk(4'b0001, 32'h0,         32'h0,         1'b1, 12'h4FF, 1'b0, 1'b0, 32'hFF00_0000, 4'b0010);
    vec[10] = mk(4'b0110, 32'h0000_F0F0, 32'h0,         1'b1, 12'h0FF, 1'b0, 1'b1, 32'h0000_00F0, 4'b0010);
    vec[11] = mk(4'b0111, 32'h0000_0100, 32'h0,         1'b1, 12'h0FF, 1'b0, 1'b0, 32'h0000_01FF, 4'b0010);
    vec[12] = mk(4'b1000, 32'h0000_00FF, 32'h0,         1'b1, 12'h0FF, 1'b0, 1'b1, 32'h0000_0000, 4'b0110);
    vec[13] = mk(4'b0000, 32'h0000_0005, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h0000_0000, 4'b0110);
    vec[14] = mk(4'b0100, 32'h8000_0000, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011);
    vec[15] = mk(4'b0010, 32'h0000_1000, 32'h0,         1'b0, 12'hFFC, 1'b1, 1'b0, 32'h0000_1FFC, 4'b0011);
    vec[16] = mk(4'b0010, 32'hFFFF_FFFF, 32'h0,         1'b1, 12'h001, 1'b0, 1'b1, 32'h0000_0000, 4'b0110);
    vec[17] = mk(4'b0001, 32'h0,         32'h1234_5678, 1'b0, 12'h060, 1'b0, 1'b0, 32'h1234_5678, 4'b0110);

    // Reset: a pending branch must not be reported while rst is low.
    rst = 1'b0;
    applyStimulus(vec[17]);
    bus.B_IN = 1'b1;
    #2;
    checkOutput("reset_status", {28'd0, bus.status}, 32'h0);
    checkOutput("reset_branch_taken", {31'd0, bus.branch_taken}, 32'h0);
    checkOutput("reset_flush", {31'd0, bus.flush}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    bus.B_IN = 1'b0;
    rst = 1'b1;

    // Table-driven ALU / shifter / flag vectors.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vec[i]);
      #2;
      checkOutput($sformatf("alu_res[%0d]", i), bus.ALU_Res, vec[i].exp_res);
      checkOutput($sformatf("mem_r_en[%0d]", i), {31'd0, bus.MEM_R_EN}, {31'd0, vec[i].mem_r});
      checkOutput($sformatf("wb_en[%0d]", i), {31'd0, bus.WB_EN}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("status[%0d]", i), {28'd0, bus.status}, {28'd0, vec[i].exp_status});
    end

    // Taken branch followed by two squashed cycles (status is 0110 here).
    @(negedge clk);
    applyStimulus(vec[17]);
    bus.B_IN             = 1'b1;
    bus.PC_IN            = 32'h0000_0100;
    bus.Signed_imm_24_IN = 24'hFFFFFE;
    bus.Dest_IN          = 4'hA;
    #2;
    checkOutput("br_addr", bus.Br_Addr, 32'h0000_00F8);
    checkOutput("br_taken", {31'd0, bus.branch_taken}, 32'd1);
    checkOutput("br_flush", {31'd0, bus.flush}, 32'd1);
    checkOutput("br_wb_en", {31'd0, bus.WB_EN}, 32'd1);
    checkOutput("br_dest", {28'd0, bus.Dest}, 32'hA);

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      applyStimulus(vec[0]);
      bus.B_IN        = 1'b1;
      bus.MEM_W_EN_IN = 1'b1;
      bus.Val_Rm_IN   = 32'hCAFE_0000;
      #2;
      checkOutput($sformatf("kill%0d_taken", k), {31'd0, bus.branch_taken}, 32'd0);
      checkOutput($sformatf("kill%0d_flush", k), {31'd0, bus.flush}, 32'd0);
      checkOutput($sformatf("kill%0d_wb_en", k), {31'd0, bus.WB_EN}, 32'd0);
      checkOutput($sformatf("kill%0d_mem_w_en", k), {31'd0, bus.MEM_W_EN}, 32'd0);
      checkOutput($sformatf("kill%0d_alu_res", k), bus.ALU_Res, 32'h8000_0000);
      checkOutput($sformatf("kill%0d_val_rm_out", k), bus.Val_Rm_out, 32'hCAFE_0000);
      @(posedge clk);
      #1;
      checkOutput($sformatf("kill%0d_status", k), {28'd0, bus.status}, 32'h6);
    end

    @(negedge clk);
    applyStimulus(vec[17]);
    #2;
    checkOutput("after_kill_wb_en", {31'd0, bus.WB_EN}, 32'd1);
`ifdef EXE_PERF_CNT_EN
    checkOutput("br_cnt", br_cnt, 32'd1);
    checkOutput("squash_cnt", squash_cnt, 32'd2);
`endif
    @(posedge clk);

    // Reset asserted during the first KILL cycle.
    @(negedge clk);
    applyStimulus(vec[17]);
    bus.B_IN = 1'b1;
    @(negedge clk);
    applyStimulus(vec[17]);
    #1;
    checkOutput("midkill_wb_en_squashed", {31'd0, bus.WB_EN}, 32'd0);
    checkOutput("midkill_status_before", {28'd0, bus.status}, 32'h6);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midkill_status_reset", {28'd0, bus.status}, 32'h0);
    checkOutput("midkill_wb_en_in_reset", {31'd0, bus.WB_EN}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_reset_wb_en", {31'd0, bus.WB_EN}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("post_reset_wb_en_next", {31'd0, bus.WB_EN}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
